// File: rtl/blockchain_present_pkg.sv
// ---------------------------------------------------------------------------
// blockchain_present_pkg
// Shared constants, helper functions and FSM state type for the reduced-width
// (16-bit block, 20-bit key) PRESENT cipher running in CBC mode.
//   SBOX / INV_SBOX : 4-bit substitution tables, entry n held at bits [4n+3:4n]
//   sbox16 / inv_sbox16 / player16 : per-block layer functions
//   get_blk / set_blk : block access, block 0 is the MS 16 bits of a message
// ---------------------------------------------------------------------------
package blockchain_present_pkg;

    localparam int unsigned BLOCK_W = 16;
    localparam int unsigned KEY_W   = 20;
    localparam int unsigned NBLOCKS = 8;
    localparam int unsigned MSG_W   = BLOCK_W * NBLOCKS;

    // S(0) lives in the LS nibble
    localparam logic [63:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] INV_SBOX = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [1:0] {
        IDLE,
        KEYGEN,
        ENC,
        DEC
    } state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] n);
        return SBOX[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] n);
        return INV_SBOX[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [BLOCK_W-1:0] sbox16(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        for (int n = 0; n < 4; n++) begin
            y[4*n +: 4] = sbox4(x[4*n +: 4]);
        end
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_sbox16(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        for (int n = 0; n < 4; n++) begin
            y[4*n +: 4] = inv_sbox4(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i -> 4i mod 15, bit 15 fixed; the mapping is an involution.
    function automatic logic [BLOCK_W-1:0] player16(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y[15] = x[15];
        for (int i = 0; i < 15; i++) begin
            y[(4 * i) % 15] = x[i];
        end
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] get_blk(input logic [MSG_W-1:0] v,
                                                   input logic [2:0]       idx);
        int unsigned base;
        base = MSG_W - 1 - BLOCK_W * int'(idx);
        return v[base -: BLOCK_W];
    endfunction

    function automatic logic [MSG_W-1:0] set_blk(input logic [MSG_W-1:0]   v,
                                                 input logic [2:0]         idx,
                                                 input logic [BLOCK_W-1:0] b);
        logic [MSG_W-1:0] r;
        int unsigned      base;
        r    = v;
        base = MSG_W - 1 - BLOCK_W * int'(idx);
        r[base -: BLOCK_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/blockchain_present_cipher_round.sv
// ---------------------------------------------------------------------------
// present16_round
// Combinational single PRESENT round on a 16-bit block.
//   i_dec   : 0 = encrypt round  P(S(x ^ rk))
//             1 = decrypt round  invS(P(x)) ^ rk
//   i_state : block value entering the round
//   i_rk    : round key for this round
//   o_state : block value leaving the round
// ---------------------------------------------------------------------------
module present16_round
    import blockchain_present_pkg::*;
(
    input  logic               i_dec,
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_rk,
    output logic [BLOCK_W-1:0] o_state
);

    always_comb begin
        if (i_dec) begin
            o_state = inv_sbox16(player16(i_state)) ^ i_rk;
        end else begin
            o_state = player16(sbox16(i_state ^ i_rk));
        end
    end

endmodule

// File: rtl/blockchain_present_cipher.sv
// ---------------------------------------------------------------------------
// blockchain_present_cipher
// Iterative PRESENT-16/20 engine: CBC-encrypts an 8-block message, then
// CBC-decrypts the result as a round-trip self-check.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request pulse, accepted only while idle
//   plaintext       : 128-bit message, block 0 in the MS 16 bits
//   key, init_vec   : 20-bit cipher key, 16-bit CBC IV
//   busy, done      : busy from acceptance to done; done is a 1-cycle pulse
//   ciphertext      : CBC ciphertext
//   deciphered_text : CBC decryption of ciphertext
// Latency: done on edge 17*ROUNDS+16 after the accepting edge.
// ---------------------------------------------------------------------------
module blockchain_present_cipher
    import blockchain_present_pkg::*;
#(
    parameter int unsigned ROUNDS = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MSG_W-1:0]   plaintext,
    input  logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] init_vec,
    output logic               busy,
    output logic               done,
    output logic [MSG_W-1:0]   ciphertext,
    output logic [MSG_W-1:0]   deciphered_text
);

    localparam logic [4:0] LAST_RND = 5'(ROUNDS);
    localparam logic [2:0] LAST_BLK = 3'(NBLOCKS - 1);

    state_e             r_state;
    state_e             w_state_next;
    logic               r_load;   // first cycle of a block (load / whitening)
    logic [4:0]         r_rnd;
    logic [2:0]         r_blk;
    logic [KEY_W-1:0]   r_key;
    // r_rk[k] holds round key RK[k+1]
    logic [BLOCK_W-1:0] r_rk [ROUNDS+1];
    logic [MSG_W-1:0]   r_pt;
    logic [BLOCK_W-1:0] r_iv;
    logic [BLOCK_W-1:0] r_x;
    logic [BLOCK_W-1:0] r_chain;
    logic [MSG_W-1:0]   r_ct_work;
    logic [MSG_W-1:0]   r_dt_work;
    logic               r_busy;
    logic               r_done;
    logic [MSG_W-1:0]   r_ct;
    logic [MSG_W-1:0]   r_dt;

    logic [KEY_W-1:0]   w_key_rot;
    logic [KEY_W-1:0]   w_key_next;
    logic [BLOCK_W-1:0] w_rk_cur;
    logic [BLOCK_W-1:0] w_rk_last;
    logic [BLOCK_W-1:0] w_round_out;
    logic [BLOCK_W-1:0] w_enc_blk;
    logic [BLOCK_W-1:0] w_dec_blk;
    logic               w_enc_last;
    logic               w_dec_last;
    logic               w_last_blk;

    // Key schedule step for round r_rnd
    assign w_key_rot  = {r_key[6:0], r_key[19:7]};
    assign w_key_next = {sbox4(w_key_rot[19:16]), w_key_rot[15:9],
                         w_key_rot[8:4] ^ r_rnd, w_key_rot[3:0]};

    assign w_rk_cur   = r_rk[r_rnd - 5'd1];
    assign w_rk_last  = r_rk[LAST_RND];

    present16_round u_round (
        .i_dec   (r_state == DEC),
        .i_state (r_x),
        .i_rk    (w_rk_cur),
        .o_state (w_round_out)
    );

    assign w_enc_blk  = w_round_out ^ w_rk_last;
    assign w_dec_blk  = w_round_out ^ r_chain;
    assign w_enc_last = (r_state == ENC) && !r_load && (r_rnd == LAST_RND);
    assign w_dec_last = (r_state == DEC) && !r_load && (r_rnd == 5'd1);
    assign w_last_blk = (r_blk == LAST_BLK);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start)                    w_state_next = KEYGEN;
            KEYGEN:  if (r_rnd == LAST_RND)        w_state_next = ENC;
            ENC:     if (w_enc_last && w_last_blk) w_state_next = DEC;
            DEC:     if (w_dec_last && w_last_blk) w_state_next = IDLE;
            default:                               w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load    <= 1'b0;
            r_rnd     <= '0;
            r_blk     <= '0;
            r_key     <= '0;
            r_pt      <= '0;
            r_iv      <= '0;
            r_x       <= '0;
            r_chain   <= '0;
            r_ct_work <= '0;
            r_dt_work <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ct      <= '0;
            r_dt      <= '0;
            for (int k = 0; k <= int'(ROUNDS); k++) begin
                r_rk[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pt    <= plaintext;
                        r_key   <= key;
                        r_iv    <= init_vec;
                        r_chain <= init_vec;
                        r_rk[0] <= key[19:4];
                        r_rnd   <= 5'd1;
                        r_busy  <= 1'b1;
                    end
                end
                KEYGEN: begin
                    r_key       <= w_key_next;
                    r_rk[r_rnd] <= w_key_next[19:4];
                    if (r_rnd == LAST_RND) begin
                        r_blk  <= '0;
                        r_load <= 1'b1;
                    end else begin
                        r_rnd <= r_rnd + 5'd1;
                    end
                end
                ENC: begin
                    if (r_load) begin
                        r_x    <= get_blk(r_pt, r_blk) ^ r_chain;
                        r_rnd  <= 5'd1;
                        r_load <= 1'b0;
                    end else if (r_rnd == LAST_RND) begin
                        r_ct_work <= set_blk(r_ct_work, r_blk, w_enc_blk);
                        r_load    <= 1'b1;
                        if (w_last_blk) begin
                            r_blk   <= '0;
                            r_chain <= r_iv;
                        end else begin
                            r_blk   <= r_blk + 3'd1;
                            r_chain <= w_enc_blk;
                        end
                    end else begin
                        r_x   <= w_round_out;
                        r_rnd <= r_rnd + 5'd1;
                    end
                end
                DEC: begin
                    if (r_load) begin
                        r_x    <= get_blk(r_ct_work, r_blk) ^ w_rk_last;
                        r_rnd  <= LAST_RND;
                        r_load <= 1'b0;
                    end else if (r_rnd == 5'd1) begin
                        r_dt_work <= set_blk(r_dt_work, r_blk, w_dec_blk);
                        r_chain   <= get_blk(r_ct_work, r_blk);
                        if (w_last_blk) begin
                            // Both result registers publish on the done edge
                            r_ct   <= r_ct_work;
                            r_dt   <= set_blk(r_dt_work, r_blk, w_dec_blk);
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                        end else begin
                            r_blk  <= r_blk + 3'd1;
                            r_load <= 1'b1;
                        end
                    end else begin
                        r_x   <= w_round_out;
                        r_rnd <= r_rnd - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign ciphertext      = r_ct;
    assign deciphered_text = r_dt;

endmodule

// File: tb/tb_blockchain_present_cipher.sv
// ---------------------------------------------------------------------------
// tb_blockchain_present_cipher
// Directed and $urandom runs of the CBC PRESENT engine against a behavioural
// reference model (table S-box, arithmetic bit permutation, straight-line
// key schedule and CBC chaining).
// ---------------------------------------------------------------------------
module tb_blockchain_present_cipher;

    localparam int ROUNDS  = 31;
    localparam int LATENCY = 17 * ROUNDS + 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] plaintext;
    logic [19:0]  key;
    logic [15:0]  init_vec;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;
    logic [127:0] deciphered_text;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] sb  [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] isb [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                             4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    blockchain_present_cipher #(.ROUNDS(ROUNDS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .plaintext       (plaintext),
        .key             (key),
        .init_vec        (init_vec),
        .busy            (busy),
        .done            (done),
        .ciphertext      (ciphertext),
        .deciphered_text (deciphered_text)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] sub16(input logic [15:0] x, input bit inv);
        logic [15:0] y;
        for (int n = 0; n < 4; n++) y[4*n +: 4] = inv ? isb[x[4*n +: 4]] : sb[x[4*n +: 4]];
        return y;
    endfunction

    function automatic logic [15:0] perm16(input logic [15:0] x, input bit inv);
        logic [15:0] y;
        for (int i = 0; i < 16; i++) begin
            int j;
            j = (i == 15) ? 15 : (4 * i) % 15;
            if (inv) y[i] = x[j];
            else     y[j] = x[i];
        end
        return y;
    endfunction

    task automatic model_run(input logic [127:0] pt, input logic [19:0] k_in,
                             input logic [15:0] iv, output logic [127:0] ct,
                             output logic [127:0] dt, output logic [15:0] rk1,
                             output logic [15:0] rk2);
        logic [15:0] rk [1:ROUNDS+1];
        int unsigned kk;
        logic [15:0] x, prev;
        kk    = k_in;
        rk[1] = kk[19:4];
        for (int r = 1; r <= ROUNDS; r++) begin
            kk = ((kk << 13) | (kk >> 7)) & 32'hFFFFF;
            kk = (kk & 32'h0FFFF) | (32'(sb[kk[19:16]]) << 16);
            kk = kk ^ (32'(r) << 4);
            rk[r+1] = kk[19:4];
        end
        rk1  = rk[1];
        rk2  = rk[2];
        prev = iv;
        for (int i = 0; i < 8; i++) begin
            x = pt[127-16*i -: 16] ^ prev;
            for (int r = 1; r <= ROUNDS; r++) x = perm16(sub16(x ^ rk[r], 0), 0);
            x = x ^ rk[ROUNDS+1];
            ct[127-16*i -: 16] = x;
            prev = x;
        end
        prev = iv;
        for (int i = 0; i < 8; i++) begin
            x = ct[127-16*i -: 16] ^ rk[ROUNDS+1];
            for (int r = ROUNDS; r >= 1; r--) x = sub16(perm16(x, 1), 1) ^ rk[r];
            dt[127-16*i -: 16] = x ^ prev;
            prev = ct[127-16*i -: 16];
        end
    endtask

    // ---------------- stimulus ----------------
    // Launches one operation; optional second start pulse at cycle 100.
    task automatic run_op(input logic [127:0] pt, input logic [19:0] k_in,
                          input logic [15:0] iv, input bit restart, output int lat);
        @(negedge clk);
        plaintext = pt;
        key       = k_in;
        init_vec  = iv;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        plaintext = ~pt;
        key       = ~k_in;
        init_vec  = ~iv;
        check("busy_after_start", 128'(busy), 128'(1'b1));
        lat = -1;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk);
            #1;
            if (restart && n == 100) start = 1'b1;
            if (restart && n == 101) begin
                start = 1'b0;
                check("busy_ignores_start", 128'(busy), 128'(1'b1));
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        check("done_latency", 128'(lat), 128'(LATENCY));
    endtask

    task automatic full_check(input string tag, input logic [127:0] pt,
                              input logic [19:0] k_in, input logic [15:0] iv,
                              input bit restart, output logic [127:0] ct_out);
        logic [127:0] e_ct, e_dt;
        logic [15:0]  rk1, rk2;
        int           lat;
        model_run(pt, k_in, iv, e_ct, e_dt, rk1, rk2);
        run_op(pt, k_in, iv, restart, lat);
        check({tag, "_ct"}, ciphertext, e_ct);
        check({tag, "_dt_model"}, deciphered_text, e_dt);
        check({tag, "_roundtrip"}, deciphered_text, pt);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 128'(done), 128'(1'b0));
        check({tag, "_busy_low"}, 128'(busy), 128'(1'b0));
        ct_out = ciphertext;
    endtask

    initial begin
        logic [127:0] ct_a, ct_b, ct_c, ct_d, pt2, e_ct, e_dt;
        logic [15:0]  rk1, rk2;
        int           diff;
        rst_n     = 1'b0;
        start     = 1'b0;
        plaintext = '0;
        key       = '0;
        init_vec  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_done", 128'(done), 128'(1'b0));
        check("rst_ct", ciphertext, 128'(0));
        check("rst_dt", deciphered_text, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Run 1: all-0x44 message
        full_check("run1", {8{16'h4444}}, 20'h48FA2, 16'hA63E, 1'b0, ct_a);
        model_run({8{16'h4444}}, 20'h48FA2, 16'hA63E, e_ct, e_dt, rk1, rk2);
        check("rk1", 128'(dut.r_rk[0]), 128'(rk1));
        check("rk2", 128'(dut.r_rk[1]), 128'(rk2));
        check("run1_ct_ne_pt", 128'(ct_a != {8{16'h4444}}), 128'(1'b1));

        // Run 2: one nibble changed in block 6
        pt2 = 128'h4444_4444_4444_4444_4444_4444_4544_4444;
        full_check("run2", pt2, 20'h48FA2, 16'hA63E, 1'b0, ct_b);
        check("run2_blk0_5_same", 128'(ct_b[127:32]), 128'(ct_a[127:32]));
        check("run2_blk6_7_diff", 128'((ct_b[31:16] != ct_a[31:16]) && (ct_b[15:0] != ct_a[15:0])),
              128'(1'b1));

        // Run 3: new IV changes every block
        full_check("run3", pt2, 20'h48FA2, 16'h48EA, 1'b0, ct_c);
        diff = 0;
        for (int i = 0; i < 8; i++) if (ct_c[127-16*i -: 16] != ct_b[127-16*i -: 16]) diff++;
        check("run3_all_blocks_diff", 128'(diff), 128'(8));

        // Run 4: new key
        full_check("run4", pt2, 20'h49FA2, 16'h48EA, 1'b0, ct_d);
        check("run4_ct_changed", 128'(ct_d != ct_c), 128'(1'b1));

        // Run 5: ignored second start mid-operation
        full_check("run5", 128'hBADDCAFEBADDF00DD15EA5EDDEADBEEF, 20'h1D1CE, 16'hAB84, 1'b1,
                   ct_a);

        // Random runs
        for (int t = 0; t < 3; t++) begin
            full_check("rand", {$urandom, $urandom, $urandom, $urandom}, 20'($urandom),
                       16'($urandom), 1'b0, ct_b);
        end

        // Abort by reset during ENC
        @(negedge clk);
        plaintext = {4{32'h1234_5678}};
        key       = 20'hC0FFE;
        init_vec  = 16'h0F0F;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'(1'b0));
        check("abort_done", 128'(done), 128'(1'b0));
        check("abort_ct", ciphertext, 128'(0));
        check("abort_dt", deciphered_text, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        full_check("post_abort", {4{32'hCAFE_F00D}}, 20'h2468A, 16'h1357, 1'b0, ct_c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
